// File: rtl/mem_sort_checker.sv
// Post-halt result checker: freezes the CPU at HALT_PC, reads a word array back and reports strict ascending order.
// Build option MEM_SORT_CHECKER_SIGNED_EN switches the neighbour compare to signed 32-bit.
module mem_sort_checker #(
    parameter logic [31:0] BASE_ADDR  = 32'd512,
    parameter int          NUM_WORDS  = 12,
    parameter logic [31:0] HALT_PC    = 32'd92,
    parameter int          RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic [31:0] mem_rd_data,
    input  logic        clear,
    output logic        cpu_hold,
    output logic        mem_rd_en,
    output logic [31:0] mem_addr,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  fail_index
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);
    localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [2:0]  lat_q, lat_d;
    logic [31:0] prev_q, prev_d;
    logic        cpu_hold_q, cpu_hold_d;
    logic        mem_rd_en_q, mem_rd_en_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [7:0]  fail_index_q, fail_index_d;
    logic        not_greater;

    function automatic logic [31:0] word_addr(input logic [7:0] i);
        return BASE_ADDR + {22'd0, i, 2'b00};
    endfunction

`ifdef MEM_SORT_CHECKER_SIGNED_EN
    assign not_greater = $signed(mem_rd_data) <= $signed(prev_q);
`else
    assign not_greater = mem_rd_data <= prev_q;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        lat_d        = lat_q;
        prev_d       = prev_q;
        cpu_hold_d   = cpu_hold_q;
        mem_rd_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        fail_index_d = fail_index_q;

        case (state_q)
            S_IDLE: begin
                if (pc == HALT_PC) begin
                    state_d     = S_READ;
                    busy_d      = 1'b1;
                    cpu_hold_d  = 1'b1;
                    idx_d       = 8'd0;
                    mem_rd_en_d = 1'b1;
                    mem_addr_d  = word_addr(8'd0);
                end
            end
            S_READ: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (lat_q > 3'd1) begin
                    lat_d = lat_q - 3'd1;
                end else if (idx_q != 8'd0 && not_greater) begin
                    state_d      = S_DONE;
                    busy_d       = 1'b0;
                    cpu_hold_d   = 1'b0;
                    done_d       = 1'b1;
                    pass_d       = 1'b0;
                    fail_index_d = idx_q;
                end else begin
                    prev_d = mem_rd_data;
                    if (idx_q == LAST_IDX) begin
                        state_d      = S_DONE;
                        busy_d       = 1'b0;
                        cpu_hold_d   = 1'b0;
                        done_d       = 1'b1;
                        pass_d       = 1'b1;
                        fail_index_d = 8'd0;
                    end else begin
                        // Next strobe is issued from this edge so READ sees it registered.
                        idx_d       = idx_q + 8'd1;
                        mem_rd_en_d = 1'b1;
                        mem_addr_d  = word_addr(idx_q + 8'd1);
                        state_d     = S_READ;
                    end
                end
            end
            S_DONE: begin
                if (clear) begin
                    state_d      = S_IDLE;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_index_d = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            idx_q        <= 8'd0;
            lat_q        <= 3'd0;
            prev_q       <= 32'd0;
            cpu_hold_q   <= 1'b0;
            mem_rd_en_q  <= 1'b0;
            mem_addr_q   <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            fail_index_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            prev_q       <= prev_d;
            cpu_hold_q   <= cpu_hold_d;
            mem_rd_en_q  <= mem_rd_en_d;
            mem_addr_q   <= mem_addr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            fail_index_q <= fail_index_d;
        end
    end

    assign cpu_hold   = cpu_hold_q;
    assign mem_rd_en  = mem_rd_en_q;
    assign mem_addr   = mem_addr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_index = fail_index_q;

endmodule

// File: doc/mem_sort_checker.md
Name: mem_sort_checker

Overview:
- Hardware result checker for the multicycle CPU; the read-back end of the memory initialisation path.
- Detects the program-halt PC, freezes the CPU, and scans a word array in unified instruction/data memory through a read port.
- Reports whether the array is strictly ascending, plus the first offending index.
- Replaces bench-side hierarchical memory peeking so that sort correctness can be checked in synthesised or on-board builds.

Parameters:
- BASE_ADDR, 512, byte address of array word 0; must be word aligned.
- NUM_WORDS, 12, number of array words scanned; legal range 1..255.
- HALT_PC, 92, PC value that triggers the scan.
- RD_LATENCY, 1, cycles from mem_rd_en to mem_rd_data valid; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- pc  in  32  current CPU program counter.
- mem_rd_data  in  32  memory read data.
- clear  in  1  one-cycle pulse; returns from DONE to IDLE.
- cpu_hold  out  1  high while scanning; CPU must stall and release the memory port.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_addr  out  32  byte address for the read.
- busy  out  1  scan in progress.
- done  out  1  scan finished; sticky.
- pass  out  1  valid when done; 1 means strictly ascending.
- fail_index  out  8  index i of the first word with a[i] <= a[i-1]; 0 when pass.

Behaviour:
- Reset (rst low at an edge) forces:
  - state IDLE
  - cpu_hold=0, mem_rd_en=0, mem_addr=0, busy=0, done=0, pass=0, fail_index=0
  - word counter, latency counter and previous-word register to 0.
- Reset is honoured in any state, including mid-scan. No read is left pending; a read in flight is discarded.
- All outputs are registered.
- States: IDLE, READ, WAIT, DONE.
- IDLE:
  - When pc == HALT_PC is sampled at an edge, go to READ.
  - At that same edge set busy=1 and cpu_hold=1, and set word counter i=0.
- READ (1 cycle):
  - mem_rd_en=1, mem_addr = BASE_ADDR + 4*i.
  - Load the latency counter with RD_LATENCY; go to WAIT.
- WAIT (RD_LATENCY cycles):
  - mem_rd_en=0.
  - On the final WAIT edge, capture mem_rd_data as cur.
  - If i == 0: store cur as prev.
  - Else if cur <= prev (unsigned 32-bit compare): go to DONE with pass=0, fail_index=i.
  - Else: store cur as prev.
  - If no fail and i == NUM_WORDS-1: go to DONE with pass=1, fail_index=0.
  - Otherwise increment i and go to READ.
- DONE:
  - busy=0, cpu_hold=0, done=1; pass and fail_index hold.
  - The pc trigger is ignored while in DONE.
  - clear=1 → IDLE, with done, pass and fail_index cleared to 0.
- Timing:
  - Each word costs RD_LATENCY+1 cycles.
  - On a full pass, done rises NUM_WORDS*(RD_LATENCY+1) cycles after the trigger edge (24 with defaults).
  - A fail at index k finishes after (k+1)*(RD_LATENCY+1) cycles.
- Scan order and addressing:
  - Scans stop at the first failure; later words are not read.
  - mem_addr is always word aligned.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
- Edge cases:
  - NUM_WORDS=1 always passes after a single read.
  - clear in any state other than DONE is ignored.
  - A trigger that coincides with clear in DONE: clear wins; a re-trigger needs pc == HALT_PC sampled again in IDLE.
  - Equal neighbours fail (strict ordering).

Optional Feature:
- Macro: MEM_SORT_CHECKER_SIGNED_EN.
- Defined: the WAIT compare is signed two's complement (cur <= prev as signed 32-bit).
- Undefined: the compare is unsigned, as described above.
- Port list and timing are identical in both builds.

Test Plan:
- Memory at 512..556 holds 0,11,22,...,121; drive pc=92 →
  - cpu_hold high for 24 cycles, 12 reads at 512,516,...,556
  - done=1, pass=1, fail_index=0.
- Same array with words 5 and 6 swapped (55,66 → 66,55) → done after 7*2=14 cycles, pass=0, fail_index=6, no read issued above 536.
- Array 55,88,0,... → pass=0, fail_index=2; then pulse clear → done=0, busy=0, state IDLE; drive pc=92 again → the scan repeats with the identical result.
- Duplicate neighbours 10,10 at indices 0,1 → pass=0, fail_index=1.
- Assert rst=0 during the 4th read → next cycle all outputs 0 and cpu_hold=0; release reset and hold pc=0 for 100 cycles → busy stays 0 and no mem_rd_en.
- Array 0xFFFFFFFF,0,1:
  - default build → pass=0, fail_index=1
  - with MEM_SORT_CHECKER_SIGNED_EN → pass=1.
